// File: rtl/fft_pkg.sv
// Shared types and default sizes for the radix-2 FFT stage sequencer
// and its butterfly address generator.
package fft_pkg;

  localparam int FFT_ADDR_W = 12;
  localparam int FFT_STG_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [FFT_ADDR_W-1:0] addr_a;
    logic [FFT_ADDR_W-1:0] addr_b;
    logic [FFT_ADDR_W-2:0] tw_idx;
    logic [FFT_STG_W-1:0]  stage;
    logic                  last;
  } bf_req_t;

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator: maps (k, s) to the operand
// pair of a DIT stage and the twiddle index into the full-size table.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int STG_W  = FFT_STG_W
) (
  input  logic [ADDR_W-2:0] k,
  input  logic [STG_W-1:0]  s,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-2:0] tw_idx
);

  localparam logic [STG_W-1:0] TOP_S = STG_W'(ADDR_W - 1);

  logic [ADDR_W-1:0] half;
  logic [ADDR_W-2:0] mask;
  logic [ADDR_W-2:0] j;
  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] g;
  logic [STG_W:0]    group_shift;

  // half is one-hot at bit s; mask keeps the bits below s (j = k mod half)
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_half
      assign half[gi] = (s == STG_W'(gi));
    end
    for (gi = 0; gi < ADDR_W - 1; gi++) begin : g_mask
      assign mask[gi] = (STG_W'(gi) < s);
    end
  endgenerate

  assign k_ext       = {1'b0, k};
  assign j           = k & mask;
  assign g           = k_ext >> s;
  assign group_shift = {1'b0, s} + (STG_W + 1)'(1);

  assign addr_a = (g << group_shift) | {1'b0, j};
  assign addr_b = addr_a | half;
  assign tw_idx = j << (TOP_S - s);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for the in-place radix-2 DIT FFT: issues one butterfly per
// handshake and holds each stage until all of its write-backs have returned.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int STG_W  = FFT_STG_W
) (
  input  logic              clk,
  input  logic              n_Reset,
  input  logic              start,
  input  logic [STG_W-1:0]  log2n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-2:0] tw_idx,
  output logic [STG_W-1:0]  stage,
  output logic              bf_last,
  input  logic              bf_wb
);

  seq_state_t        state_reg, state_next;
  logic [STG_W-1:0]  l_reg, l_next;
  logic [STG_W-1:0]  s_reg, s_next;
  logic [ADDR_W-2:0] k_reg, k_next;
  logic [ADDR_W-1:0] outst_reg, outst_next;

  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              valid_reg, valid_next;
  bf_req_t           req_reg, req_next;

  logic              log2n_ok;
  logic              handshake;
  logic [ADDR_W-1:0] n_half;
  logic [ADDR_W-2:0] k_last;
  logic [ADDR_W-1:0] gen_a;
  logic [ADDR_W-1:0] gen_b;
  logic [ADDR_W-2:0] gen_tw;

  assign log2n_ok  = (log2n != '0) && (int'(log2n) <= ADDR_W);
  assign handshake = (state_reg == ISSUE) && bf_ready;

  // last butterfly index of a stage is N/2-1; tracks l_next so a freshly
  // latched size already applies to the first registered request
  assign n_half = ADDR_W'(1) << (l_next - STG_W'(1));
  assign k_last = n_half[ADDR_W-2:0] - (ADDR_W-1)'(1);

  // The request registers are loaded from the generator on the next (k, s).
  fft_bf_addr_gen #(
    .ADDR_W (ADDR_W),
    .STG_W  (STG_W)
  ) u_addr_gen (
    .k      (k_next),
    .s      (s_next),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  always_ff @(posedge clk or negedge n_Reset) begin
    if (!n_Reset) begin
      state_reg <= IDLE;
      l_reg     <= '0;
      s_reg     <= '0;
      k_reg     <= '0;
      outst_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      l_reg     <= l_next;
      s_reg     <= s_next;
      k_reg     <= k_next;
      outst_reg <= outst_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      valid_reg <= valid_next;
      req_reg   <= req_next;
    end
  end

  // Write-backs with nothing outstanding are dropped rather than wrapping.
  always_comb begin
    outst_next = outst_reg;
    if (handshake && !bf_wb) begin
      outst_next = outst_reg + ADDR_W'(1);
    end else if (!handshake && bf_wb && (outst_reg != '0)) begin
      outst_next = outst_reg - ADDR_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    l_next     = l_reg;
    s_next     = s_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (start && log2n_ok) begin
          state_next = ISSUE;
          l_next     = log2n;
          s_next     = '0;
          k_next     = '0;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (k_reg == k_last) begin
            state_next = DRAIN;
          end else begin
            k_next = k_reg + (ADDR_W-1)'(1);
          end
        end
      end
      DRAIN: begin
        if (outst_next == '0) begin
          if (s_reg == l_reg - STG_W'(1)) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
            s_next     = s_reg + STG_W'(1);
            k_next     = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
    valid_next = (state_next == ISSUE);
    err_next   = (state_reg == IDLE) && start && !log2n_ok;
    req_next   = '0;
    if (state_next != IDLE) begin
      req_next.addr_a = gen_a;
      req_next.addr_b = gen_b;
      req_next.tw_idx = gen_tw;
      req_next.stage  = s_next;
      req_next.last   = (state_next == ISSUE) && (k_next == k_last);
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign bf_valid = valid_reg;
  assign addr_a   = req_reg.addr_a;
  assign addr_b   = req_reg.addr_b;
  assign tw_idx   = req_reg.tw_idx;
  assign stage    = req_reg.stage;
  assign bf_last  = req_reg.last;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: runs whole transforms against an
// expected butterfly list and checks handshake, drain and done timing.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int AW    = FFT_ADDR_W;
  localparam int SW    = FFT_STG_W;
  localparam int LIMIT = 40000;

  logic          clk = 1'b0;
  logic          n_Reset;
  logic          start;
  logic [SW-1:0] log2n;
  logic          busy;
  logic          done;
  logic          err;
  logic          bf_valid;
  logic          bf_ready;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-2:0] tw_idx;
  logic [SW-1:0] stage;
  logic          bf_last;
  logic          bf_wb;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    bit last;
  } exp_t;

  exp_t exp_q[$];

  // hand-computed 8-point sequence
  int tab_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tab_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tab_tw [12] = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};

  always #5 clk = ~clk;

  fft_stage_sequencer dut (
    .clk      (clk),
    .n_Reset  (n_Reset),
    .start    (start),
    .log2n    (log2n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bf_valid (bf_valid),
    .bf_ready (bf_ready),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .tw_idx   (tw_idx),
    .stage    (stage),
    .bf_last  (bf_last),
    .bf_wb    (bf_wb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected list walks groups of 2*half points, wing offset j inside each.
  function automatic void build_exp(input int l);
    exp_t e;
    int n;
    int half;
    exp_q.delete();
    if (l == 3) begin
      for (int i = 0; i < 12; i++) begin
        e.a    = tab_a[i];
        e.b    = tab_b[i];
        e.tw   = tab_tw[i];
        e.st   = i / 4;
        e.last = (i % 4 == 3);
        exp_q.push_back(e);
      end
    end else begin
      n = 1 << l;
      for (int s = 0; s < l; s++) begin
        half = 1 << s;
        for (int base = 0; base < n; base += 2 * half) begin
          for (int j = 0; j < half; j++) begin
            e.a    = base + j;
            e.b    = base + j + half;
            e.tw   = j * ((1 << (AW - 1)) / half);
            e.st   = s;
            e.last = (base + 2 * half == n) && (j == half - 1);
            exp_q.push_back(e);
          end
        end
      end
    end
  endfunction

  // rmode: 0 ready always high, 1 ready pattern 1-0-0-1.
  // hold_idx: handshake whose write-back is delayed 20 cycles (-1 none).
  // intr_at / abort_at: handshake index at which a stray start or reset hits.
  task automatic run_fft(input string name, input int l, input int rmode, input int lat,
                         input int hold_idx, input int intr_at, input int abort_at);
    int  hs;
    int  outst;
    int  cyc;
    int  phase;
    int  total;
    bit  finished;
    bit  hs_now;
    bit  wb_now;
    bit  intr_done;
    int  wbq[$];
    build_exp(l);
    total     = exp_q.size();
    hs        = 0;
    outst     = 0;
    cyc       = 0;
    phase     = 0;
    finished  = 1'b0;
    intr_done = 1'b0;
    bf_ready  = 1'b0;
    bf_wb     = 1'b0;
    start     = 1'b1;
    log2n     = SW'(l);
    step();
    start = 1'b0;
    log2n = SW'(l) ^ SW'(5);
    while (!finished && cyc < LIMIT) begin
      chk("err_low", err, 0);
      case (phase)
        0: begin
          chk("valid", bf_valid, 1);
          chk("addr_a", addr_a, exp_q[hs].a);
          chk("addr_b", addr_b, exp_q[hs].b);
          chk("tw_idx", tw_idx, exp_q[hs].tw);
          chk("stage", stage, exp_q[hs].st);
          chk("bf_last", bf_last, exp_q[hs].last);
          chk("busy_run", busy, 1);
          chk("done_early", done, 0);
        end
        1: begin
          chk("drain_valid", bf_valid, 0);
          chk("drain_stage", stage, exp_q[hs-1].st);
          chk("busy_drain", busy, 1);
          chk("done_early", done, 0);
        end
        2: begin
          chk("done_pulse", done, 1);
          chk("busy_done", busy, 1);
          chk("done_valid", bf_valid, 0);
        end
        default: begin
          chk("done_single", done, 0);
          chk("busy_fall", busy, 0);
          chk("idle_valid", bf_valid, 0);
          finished = 1'b1;
        end
      endcase
      if (phase == 0 && hs == abort_at) begin
        n_Reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_valid", bf_valid, 0);
        chk("arst_addr_a", addr_a, 0);
        chk("arst_addr_b", addr_b, 0);
        chk("arst_tw", tw_idx, 0);
        chk("arst_stage", stage, 0);
        chk("arst_last", bf_last, 0);
        step();
        chk("arst_no_done", done, 0);
        // stale write-backs after reset must not disturb the next run
        n_Reset  = 1'b1;
        bf_ready = 1'b0;
        bf_wb    = 1'b1;
        step();
        step();
        bf_wb = 1'b0;
        chk("post_rst_busy", busy, 0);
        $display("[TB] run %s: L=%0d aborted by reset after %0d handshakes", name, l, hs);
        return;
      end
      if (!finished) begin
        start = 1'b0;
        if (phase == 0 && hs == intr_at && !intr_done) begin
          start     = 1'b1;
          log2n     = SW'(2);
          intr_done = 1'b1;
        end
        bf_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        hs_now   = (phase == 0) && bf_ready;
        if (hs_now)
          wbq.push_back(cyc + ((hs == hold_idx) ? 20 : lat));
        wb_now = 1'b0;
        for (int i = 0; i < wbq.size(); i++) begin
          if (wbq[i] == cyc) begin
            wbq.delete(i);
            wb_now = 1'b1;
            break;
          end
        end
        bf_wb = wb_now;
        outst = outst + int'(hs_now) - int'(wb_now);
        case (phase)
          0: if (hs_now) begin
            if (exp_q[hs].last) phase = 1;
            hs++;
          end
          1: if (outst == 0) phase = (hs < total) ? 0 : 2;
          2: phase = 3;
          default: phase = 3;
        endcase
        step();
        cyc++;
      end
    end
    start    = 1'b0;
    bf_wb    = 1'b0;
    bf_ready = 1'b0;
    chk("run_complete", finished, 1);
    $display("[TB] run %s: L=%0d handshakes=%0d cycles=%0d", name, l, hs, cyc);
  endtask

  initial begin
    logic [SW-1:0] bad_l [2];
    bad_l[0] = SW'(0);
    bad_l[1] = SW'(13);
    n_Reset  = 1'b0;
    start    = 1'b0;
    log2n    = '0;
    bf_ready = 1'b0;
    bf_wb    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", bf_valid, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_tw", tw_idx, 0);
    chk("rst_stage", stage, 0);
    chk("rst_last", bf_last, 0);
    n_Reset = 1'b1;
    step();

    run_fft("l3_basic", 3, 0, 3, -1, -1, -1);
    run_fft("l3_stall", 3, 1, 3, -1, -1, -1);
    run_fft("l3_hold_wb", 3, 0, 3, 3, -1, -1);
    run_fft("l4_start_then_reset", 4, 0, 2, -1, 10, 19);
    run_fft("l2_after_reset", 2, 0, 2, -1, -1, -1);

    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      log2n = bad_l[i];
      step();
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", bf_valid, 0);
      step();
      chk("err_clear", err, 0);
      chk("err_busy2", busy, 0);
      chk("err_valid2", bf_valid, 0);
      $display("[TB] bad start log2n=%0d", bad_l[i]);
    end

    run_fft("l1_single", 1, 0, 1, -1, -1, -1);
    run_fft("l12_full", 12, 0, 0, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer for the radix-2 in-place FFT datapath behind the AXI sample buffer.
- On start, walks all log2(N) decimation-in-time stages and issues one butterfly request per cycle: operand addresses A/B, twiddle index and stage number.
- Enforces a stage barrier: stage s+1 is not issued until every write-back from stage s has returned.
- Input samples are already in bit-reversed order in sample memory; output is natural order.

Parameters:
- ADDR_W, 12, sample-memory address width; max N = 2^ADDR_W = 4096 points.
- STG_W, 4, width of the stage and log2n fields; must satisfy 2^STG_W > ADDR_W.

Ports:
- clk  in  1  system clock.
- n_Reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a transform; honoured only in IDLE.
- log2n  in  STG_W  transform size exponent; sampled on an accepted start.
- busy  out  1  high from the accepted start up to and including the done cycle.
- done  out  1  one-cycle pulse when the last stage has fully drained.
- err  out  1  one-cycle pulse when start arrives with an invalid log2n.
- bf_valid  out  1  butterfly request valid.
- bf_ready  in  1  butterfly unit accepts the request.
- addr_a  out  ADDR_W  upper-wing operand address.
- addr_b  out  ADDR_W  lower-wing operand address (addr_a + 2^stage).
- tw_idx  out  ADDR_W-1  twiddle ROM index, scaled to an N_max-point table.
- stage  out  STG_W  current stage, 0 .. L-1.
- bf_last  out  1  marks the final butterfly of the current stage.
- bf_wb  in  1  pulse: one butterfly result written back to memory.

Behaviour:
- Reset (async, n_Reset=0): state=IDLE. All outputs 0. Internal k, s and outstanding counters = 0. Reset mid-transform aborts immediately with no done pulse. Write-backs arriving after reset are ignored because outstanding is 0.
- Notation: L = log2n latched at start, N = 2^L, half = 2^s.
- Valid log2n range: 1 .. ADDR_W.
- Butterfly index k runs 0 .. N/2-1 within each stage.
  - j = k & (half-1); g = k >> s.
  - addr_a = (g << (s+1)) | j; addr_b = addr_a | half.
  - tw_idx = j << (ADDR_W-1-s), always using the max-size table.
- States:
  - IDLE:
    - start with valid log2n: latch L, set s=0, k=0, go to ISSUE; busy=1 from the next cycle.
    - start with invalid log2n (0 or > ADDR_W): err=1 for the next cycle, stay IDLE.
  - ISSUE:
    - bf_valid=1. Outputs are registered and held stable while bf_valid && !bf_ready.
    - On handshake: k++, next butterfly is presented the following cycle.
    - On handshake with k = N/2-1 (bf_last=1): go to DRAIN; bf_valid=0 next cycle.
  - DRAIN:
    - bf_valid=0. Wait until outstanding == 0, evaluated after this cycle's update.
    - If s < L-1: s++, k=0, return to ISSUE.
    - If s = L-1: go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Latency:
  - start accepted at cycle t → first request valid at t+1.
  - Last stage drained at cycle d → done at d+1.
  - With bf_ready=1 throughout, each stage issues N/2 butterflies back to back.
- Outstanding counter (ADDR_W bits):
  - +1 on handshake, -1 on bf_wb.
  - Simultaneous handshake and bf_wb: counter unchanged.
  - bf_wb with outstanding == 0: ignored, counter stays 0 (no underflow).
- Start while busy: ignored, no err.
- log2n is ignored except on an accepted start; changing it mid-run has no effect.
- L=1: single stage, single butterfly (0,1), tw 0.

Decomposition:
- fft_pkg holds:
  - typedef enum {IDLE, ISSUE, DRAIN, DONE} seq_state_t;
  - localparams FFT_ADDR_W=12 and FFT_STG_W=4;
  - a bf_req_t struct {addr_a, addr_b, tw_idx, stage, last}.
- Sub-module fft_bf_addr_gen: purely combinational (k, s) → addr_a, addr_b, tw_idx. It is reused by the datapath bench model.
- The FSM and counters stay in fft_stage_sequencer.

Test Plan:
- log2n=3, bf_ready=1, bf_wb returned 3 cycles after each handshake →
  - stage0 issues (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0;
  - stage1 issues (0,2),(1,3),(4,6),(5,7) with tw 0,1024,0,1024;
  - stage2 issues (0,4),(1,5),(2,6),(3,7) with tw 0,512,1024,1536;
  - 12 handshakes total, bf_last on the 4th/8th/12th, a single done pulse, busy then falls.
- Same run with bf_ready toggling 1-0-0-1 → request fields held unchanged while stalled; identical address sequence; done still a single pulse.
- Withhold bf_wb for the final stage-0 butterfly for 20 cycles → stay in DRAIN with bf_valid=0 and stage=0 throughout; stage1 (0,2) appears exactly 1 cycle after the outstanding count hits 0.
- start with log2n=0, then with log2n=13 → err pulses once each, busy stays 0, bf_valid never asserts. Then log2n=1 → single request (0,1) tw 0, done after its write-back.
- Assert start during stage 1 of a log2n=4 run → ignored, sequence unchanged. Then assert n_Reset=0 mid-stage-2 → all outputs 0 asynchronously, no done. New start after reset → stage0 k0 (0,1).
- log2n=12, ready=1, immediate write-backs → 12×2048 handshakes. Check the last request is (2047,4095) with tw 2047; no outstanding-counter overflow or underflow.
